// File: rtl/lfsr_spawn_timer.sv
// lfsr_spawn_timer
// XNOR Fibonacci LFSR feeding a random-interval countdown. Each interval is
// MIN_INTERVAL plus the current LFSR value; when the countdown expires, a spawn
// request is raised and held until the game FSM acknowledges it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; waits for the first enabled edge to load an interval
// COUNT | countdown running on enabled edges; spawn low
// FIRE  | spawn request held high, count held at 0, waits for spawn_ack
//
// Every output is driven directly by a flop. All-ones is the LFSR lockup state.
// A seed of all-ones is therefore loaded as zero.
module lfsr_spawn_timer #(
   parameter int               WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = 4'b1001,
   parameter int               MIN_INTERVAL = 15,
   parameter int               CNT_W        = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             spawn_ack_i,
   output logic [WIDTH-1:0] rand_o,
   output logic             spawn_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_INTERVAL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      FIRE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rand_q, rand_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             spawn_q, spawn_d;
   logic             fb;
   logic [CNT_W-1:0] interval;

   // LFSR next state: a seed load overrides the step; the step runs in every FSM state
   always_comb begin
      rand_d = rand_q;
      fb     = ~^(rand_q & TAPS);
      if (seed_load_i) begin
         rand_d = (seed_i == ALL_ONES) ? '0 : seed_i;
      end else if (en_i) begin
         rand_d = {fb, rand_q[WIDTH-1:1]};
      end
   end

   // The interval is built from the LFSR value before this edge's step or load
   assign interval = MIN_C + CNT_W'(rand_q);

   // Timer FSM next state, countdown and spawn request
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      spawn_d = spawn_q;
      case (state_q)
         IDLE: begin
            spawn_d = 1'b0;
            if (en_i) begin
               state_d = COUNT;
               count_d = interval;
            end
         end
         COUNT: begin
            spawn_d = 1'b0;
            if (en_i) begin
               if (count_q != '0) begin
                  count_d = count_q - CNT_W'(1);
               end else begin
                  state_d = FIRE;
                  spawn_d = 1'b1;
               end
            end
         end
         FIRE: begin
            spawn_d = 1'b1;
            count_d = '0;
            // Acknowledge is taken whether or not the timer is enabled
            if (spawn_ack_i) begin
               state_d = COUNT;
               count_d = interval;
               spawn_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
            spawn_d = 1'b0;
         end
      endcase
   end

   // State registers; reset clears everything immediately
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         rand_q  <= '0;
         count_q <= '0;
         spawn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rand_q  <= rand_d;
         count_q <= count_d;
         spawn_q <= spawn_d;
      end
   end

   assign rand_o  = rand_q;
   assign spawn_o = spawn_q;
   assign count_o = count_q;

endmodule

// File: tb/tb_lfsr_spawn_timer.sv
// Testbench for lfsr_spawn_timer (default parameters).
// The reference model tracks the LFSR as a position in the documented 15-entry
// sequence. It tracks the timer as a mode plus an integer countdown.
module tb_lfsr_spawn_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       seed_load;
   logic [3:0] seed;
   logic       spawn_ack;
   logic [3:0] rand_w;
   logic       spawn;
   logic [7:0] count;

   lfsr_spawn_timer dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .en_i        (en),
      .seed_load_i (seed_load),
      .seed_i      (seed),
      .spawn_ack_i (spawn_ack),
      .rand_o      (rand_w),
      .spawn_o     (spawn),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Documented default sequence starting from 0 (period 15, 4'hF absent)
   int seq [15] = '{0, 8, 4, 10, 5, 2, 9, 12, 6, 11, 13, 14, 7, 3, 1};

   // Model: m_idx = position in seq, m_mode 0=idle 1=counting 2=firing
   int m_idx, m_mode, m_cnt;

   function automatic int pos_of(input int v);
      for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx  = 0;
      m_mode = 0;
      m_cnt  = 0;
   endtask

   // Apply one clock edge to the model using the inputs currently driven
   task automatic model_edge();
      int ivl;
      ivl = 15 + seq[m_idx];
      case (m_mode)
         0: if (en) begin m_mode = 1; m_cnt = ivl; end
         1: if (en) begin
               if (m_cnt > 0) m_cnt = m_cnt - 1;
               else m_mode = 2;
            end
         default: if (spawn_ack) begin m_mode = 1; m_cnt = ivl; end
      endcase
      if (seed_load) m_idx = (seed == 4'hF) ? 0 : pos_of(int'(seed));
      else if (en)   m_idx = (m_idx + 1) % 15;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_rand"},  32'(rand_w), 32'(seq[m_idx]));
      chk({tag, "_spawn"}, 32'(spawn),  32'(m_mode == 2));
      chk({tag, "_count"}, 32'(count),  32'(m_cnt));
      chk({tag, "_nolock"}, 32'(rand_w == 4'hF), 32'd0);
   endtask

   // Drive inputs, take one edge, sample 1 time unit after the edge
   task automatic cyc(input logic e, input logic sl, input logic [3:0] sd, input logic ak,
                      input string tag);
      en = e; seed_load = sl; seed = sd; spawn_ack = ak;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      int n;
      int held;
      logic e;
      reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed = 4'h0; spawn_ack = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // LFSR sequence from 0 and first interval: load 15, spawn on the 17th edge
      cyc(1'b1, 1'b0, 4'h0, 1'b0, "t2_load");
      chk("t2_first_count", 32'(count), 32'd15);
      n = 1;
      while (!spawn && n < 40) begin
         cyc(1'b1, 1'b0, 4'h0, 1'b0, "t1_step");
         n++;
      end
      chk("t2_rise_edge", 32'(n), 32'd17);
      repeat (5) cyc(1'b1, 1'b0, 4'h0, 1'b0, "t2_hold");
      chk("t2_still_spawn", 32'(spawn), 32'd1);

      // Seed 4'hA while firing, then acknowledge: interval 25, spawn after 26 enabled edges
      cyc(1'b0, 1'b1, 4'hA, 1'b0, "t3_seed");
      chk("t3_rand_a", 32'(rand_w), 32'hA);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, "t3_ack");
      chk("t3_count25", 32'(count), 32'd25);
      chk("t3_spawn_low", 32'(spawn), 32'd0);
      n = 0;
      while (!spawn && n < 200) begin
         e = ($urandom_range(0, 3) != 0);
         cyc(e, 1'b0, 4'h0, 1'b0, "t3_run");
         if (e) n++;
      end
      chk("t3_gap", 32'(n), 32'd26);

      // Seed loads while firing: all-ones loads 0, seed beats step, count untouched
      cyc(1'b0, 1'b1, 4'hF, 1'b0, "t4_f");
      chk("t4_rand0", 32'(rand_w), 32'd0);
      cyc(1'b1, 1'b1, 4'h5, 1'b0, "t4_5");
      chk("t4_rand5", 32'(rand_w), 32'd5);
      chk("t4_count", 32'(count), 32'd0);

      // Freeze with en=0 mid-count, then resume; ack in COUNT is ignored
      cyc(1'b0, 1'b0, 4'h0, 1'b1, "t5_ack");
      chk("t5_count20", 32'(count), 32'd20);
      repeat (4) cyc(1'b1, 1'b0, 4'h0, 1'b0, "t5_run");
      held = int'(count);
      repeat (10) cyc(1'b0, 1'b0, 4'h0, 1'b0, "t5_freeze");
      chk("t5_held", 32'(count), 32'(held));
      cyc(1'b1, 1'b0, 4'h0, 1'b1, "t6_ack_in_count");
      chk("t5_resume", 32'(count), 32'(held - 1));

      // Randomised phase
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
             4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rnd");
      end

      // Reach FIRE, then assert reset between edges
      n = 0;
      while (!spawn && n < 100) begin
         cyc(1'b1, 1'b0, 4'h0, 1'b0, "t6_run");
         n++;
      end
      chk("t6_fire", 32'(spawn), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      chk("t6_async_spawn", 32'(spawn), 32'd0);
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_rand", 32'(rand_w), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 4'h0, 1'b0, "t6_restart");
      chk("t6_reload", 32'(count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
